// File: rtl/sync_vc_fifo.sv
// Multi-channel synchronous FIFO: NUM_VC independent circular queues sharing one write and one read port.
// Define SYNC_VC_FIFO_FWFT_EN for first-word-fall-through reads; the default build registers read data.
module sync_vc_fifo #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 16,
    parameter  int NUM_VC   = 4,
    parameter  int AF_LEVEL = DEPTH - 2,
    localparam int VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int ADDR_W   = $clog2(DEPTH),
    localparam int PTR_W    = ADDR_W + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WINC,
    input  logic [VC_W-1:0]   WVC,
    input  logic [WIDTH-1:0]  WDATA,
    input  logic              RINC,
    input  logic [VC_W-1:0]   RVC,
    output logic [WIDTH-1:0]  RDATA,
    output logic              RVALID,
    output logic [NUM_VC-1:0] WFULL,
    output logic [NUM_VC-1:0] REMPTY,
    output logic [NUM_VC-1:0] WAFULL,
    output logic              OVF,
    output logic              UDF
);

    localparam int               VC_SPAN = 1 << VC_W;
    localparam logic [PTR_W-1:0] AF_PTR  = PTR_W'(AF_LEVEL);

    logic [WIDTH-1:0]   mem [NUM_VC][DEPTH];
    logic [PTR_W-1:0]   wptr [NUM_VC];
    logic [PTR_W-1:0]   rptr [NUM_VC];

    logic [VC_SPAN-1:0] full_pad;
    logic [VC_SPAN-1:0] empty_pad;
    logic               wvc_in;
    logic               rvc_in;
    logic               wr_ok;
    logic               rd_ok;
    logic [WIDTH-1:0]   head_data;

    // Flags come straight from the registered pointers, so they show an operation one cycle after its edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a path that skips the assignment infers a latch.
        WFULL  = '0;
        REMPTY = '0;
        WAFULL = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            logic [PTR_W-1:0] occ;
            occ       = wptr[v] - rptr[v];
            REMPTY[v] = (wptr[v] == rptr[v]);
            WFULL[v]  = (wptr[v][ADDR_W-1:0] == rptr[v][ADDR_W-1:0]) &&
                        (wptr[v][ADDR_W] != rptr[v][ADDR_W]);
            WAFULL[v] = (occ >= AF_PTR);
        end
    end

    // Padding to a power-of-two span lets an out-of-range channel index select a harmless bit.
    assign full_pad  = VC_SPAN'(WFULL);
    assign empty_pad = VC_SPAN'(REMPTY);
    assign wvc_in    = (32'(WVC) < 32'(NUM_VC));
    assign rvc_in    = (32'(RVC) < 32'(NUM_VC));
    assign wr_ok     = WINC && wvc_in && !full_pad[WVC];
    assign rd_ok     = RINC && rvc_in && !empty_pad[RVC];
    assign head_data = mem[RVC][rptr[RVC][ADDR_W-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int v = 0; v < NUM_VC; v++) begin
                // NOTE: non-blocking assignments make every update in this block see the pre-edge state, which the acceptance rules depend on.
                wptr[v] <= '0;
                rptr[v] <= '0;
            end
            OVF <= 1'b0;
            UDF <= 1'b0;
        end else begin
            if (wr_ok)
                wptr[WVC] <= wptr[WVC] + 1'b1;
            if (rd_ok)
                rptr[RVC] <= rptr[RVC] + 1'b1;
            if (WINC && !wr_ok)
                OVF <= 1'b1;
            if (RINC && !rd_ok)
                UDF <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; contents are meaningless until written because the pointers are reset.
    always_ff @(posedge CLK) begin
        if (!RST && wr_ok)
            mem[WVC][wptr[WVC][ADDR_W-1:0]] <= WDATA;
    end

`ifdef SYNC_VC_FIFO_FWFT_EN
    // Head of the selected channel is shown before the pop; zero whenever nothing is valid.
    assign RVALID = rvc_in && !empty_pad[RVC];
    assign RDATA  = RVALID ? head_data : '0;
`else
    logic             rvalid_q;
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_ok;
            if (rd_ok)
                rdata_q <= head_data;
        end
    end

    assign RVALID = rvalid_q;
    assign RDATA  = rdata_q;
`endif

endmodule

// File: tb/tb_sync_vc_fifo.sv
// Randomized scoreboard bench for sync_vc_fifo: per-channel queue model, a stimulus process and a separate read monitor.
// Works for both read modes; compile with SYNC_VC_FIFO_FWFT_EN to check the fall-through build.
module tb_sync_vc_fifo;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int NUM_VC = 4;
    localparam int AF     = DEPTH - 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              WINC;
    logic [1:0]        WVC;
    logic [WIDTH-1:0]  WDATA;
    logic              RINC;
    logic [1:0]        RVC;
    logic [WIDTH-1:0]  RDATA;
    logic              RVALID;
    logic [NUM_VC-1:0] WFULL;
    logic [NUM_VC-1:0] REMPTY;
    logic [NUM_VC-1:0] WAFULL;
    logic              OVF;
    logic              UDF;

    sync_vc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
        .CLK(CLK), .RST(RST), .WINC(WINC), .WVC(WVC), .WDATA(WDATA),
        .RINC(RINC), .RVC(RVC), .RDATA(RDATA), .RVALID(RVALID),
        .WFULL(WFULL), .REMPTY(REMPTY), .WAFULL(WAFULL), .OVF(OVF), .UDF(UDF)
    );

    always #5 CLK = ~CLK;

    int              total = 0;
    int              bad   = 0;
    logic [WIDTH-1:0] model_q [NUM_VC][$];
    logic [WIDTH-1:0] exp_q [$];
    bit              model_ovf;
    bit              model_udf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_flags();
        logic [NUM_VC-1:0] e_empty, e_full, e_af;
        for (int v = 0; v < NUM_VC; v++) begin
            e_empty[v] = (model_q[v].size() == 0);
            e_full[v]  = (model_q[v].size() == DEPTH);
            e_af[v]    = (model_q[v].size() >= AF);
        end
        check("REMPTY", 32'(REMPTY), 32'(e_empty));
        check("WFULL",  32'(WFULL),  32'(e_full));
        check("WAFULL", 32'(WAFULL), 32'(e_af));
        check("OVF",    32'(OVF),    32'(model_ovf));
        check("UDF",    32'(UDF),    32'(model_udf));
    endtask

    // Entered just after a rising edge; leaves just after the next one with flags checked.
    task automatic step(input bit winc, input logic [1:0] wvc, input logic [WIDTH-1:0] wdata,
                        input bit rinc, input logic [1:0] rvc);
        bit wr_acc, rd_acc;
        WINC = winc; WVC = wvc; WDATA = wdata; RINC = rinc; RVC = rvc;
        #2;
`ifdef SYNC_VC_FIFO_FWFT_EN
        check("fwft_rvalid", 32'(RVALID), 32'(model_q[rvc].size() != 0));
        if (model_q[rvc].size() != 0)
            check("fwft_head", 32'(RDATA), 32'(model_q[rvc][0]));
`endif
        wr_acc = winc && (model_q[wvc].size() < DEPTH);
        rd_acc = rinc && (model_q[rvc].size() > 0);
        if (rd_acc)
            exp_q.push_back(model_q[rvc].pop_front());
        if (wr_acc)
            model_q[wvc].push_back(wdata);
        if (winc && !wr_acc) model_ovf = 1'b1;
        if (rinc && !rd_acc) model_udf = 1'b1;
        @(posedge CLK);
        #1;
        check_flags();
    endtask

    // Requests are held high during reset to show they are ignored.
    task automatic do_reset();
        RST = 1'b1; WINC = 1'b1; RINC = 1'b1; WVC = '0; RVC = '0; WDATA = 8'hEE;
        @(posedge CLK);
        #1;
        RST = 1'b0; WINC = 1'b0; RINC = 1'b0;
        for (int v = 0; v < NUM_VC; v++) model_q[v].delete();
        model_ovf = 1'b0;
        model_udf = 1'b0;
        check_flags();
        check("rvalid_rst", 32'(RVALID), 32'd0);
        check("rdata_rst",  32'(RDATA),  32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents read data.
    initial begin
        forever begin
            @(negedge CLK);
`ifdef SYNC_VC_FIFO_FWFT_EN
            if (!RST && RINC && RVALID) begin
`else
            if (RVALID) begin
`endif
                if (exp_q.size() == 0)
                    check("sb_underrun", 32'(exp_q.size()), 32'd1);
                else
                    check("rdata", 32'(RDATA), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        WINC = 0; RINC = 0; WVC = 0; RVC = 0; WDATA = 0; RST = 1;
        do_reset();

        // Fill VC0 with 0..15, watching the almost-full and full boundaries.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 2'd0, 8'(i), 1'b0, 2'd0);
            if (i == AF - 2) check("waf0_before", 32'(WAFULL[0]), 32'd0);
            if (i == AF - 1) check("waf0_at",     32'(WAFULL[0]), 32'd1);
            if (i == DEPTH - 2) check("wfull0_before", 32'(WFULL[0]), 32'd0);
        end
        check("wfull0_at", 32'(WFULL[0]), 32'd1);
        check("rempty123", 32'(REMPTY[3:1]), 32'h7);

        // Write into a full channel is dropped; the 16 stored words drain in order.
        step(1'b1, 2'd0, 8'hAA, 1'b0, 2'd0);
        check("ovf_full", 32'(OVF), 32'd1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        check("rempty0_drained", 32'(REMPTY[0]), 32'd1);

        // Interleaved channels, read back in the opposite channel order.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 2'd1, 8'(8'h10 + i), 1'b0, 2'd0);
            step(1'b1, 2'd2, 8'(8'h20 + i), 1'b0, 2'd0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);

        // Same-channel collisions on a full and on an empty channel.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd3, 8'(8'h30 + i), 1'b0, 2'd0);
        step(1'b1, 2'd3, 8'h77, 1'b1, 2'd3);
        check("ovf_collide", 32'(OVF), 32'd1);
        check("wfull3_after", 32'(WFULL[3]), 32'd0);
        step(1'b1, 2'd2, 8'h33, 1'b1, 2'd2);
        check("udf_collide", 32'(UDF), 32'd1);
        check("rempty2_after", 32'(REMPTY[2]), 32'd0);
        // Partially filled channel: simultaneous push and pop keep occupancy.
        step(1'b1, 2'd3, 8'h78, 1'b1, 2'd3);

        // Reset mid-operation discards queued data.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 2'd0, 8'(8'h40 + i), 1'b0, 2'd0);
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
        do_reset();
        check("rempty_all_rst", 32'(REMPTY), 32'hF);
        step(1'b1, 2'd0, 8'h5A, 1'b0, 2'd0);
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0)
                do_reset();
            else
                step($urandom_range(0, 99) < 55, 2'($urandom_range(0, 3)), 8'($urandom),
                     $urandom_range(0, 99) < 50, 2'($urandom_range(0, 3)));
        end

        // Drain everything and let the monitor see the last word.
        for (int v = 0; v < NUM_VC; v++)
            while (model_q[v].size() != 0) step(1'b0, 2'd0, 8'h00, 1'b1, 2'(v));
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_vc_fifo.md
SYNC_VC_FIFO -- requirements
Module: sync_vc_fifo

Interface
REQ-001 Parameter WIDTH, default 8, bits per data word.
REQ-002 Parameter DEPTH, default 16, entries per channel; power of two, >= 2.
REQ-003 Parameter NUM_VC, default 4, number of independent virtual-channel queues; >= 1.
REQ-004 Parameter AF_LEVEL, default DEPTH-2, occupancy at or above which almost-full asserts.
REQ-005 Derived VC_W = max(1, clog2(NUM_VC)); ADDR_W = clog2(DEPTH); PTR_W = ADDR_W+1.
REQ-006 CLK  in  1  single clock; all logic on rising edge.
REQ-007 RST  in  1  synchronous, active-high reset.
REQ-008 WINC  in  1  write request.
REQ-009 WVC  in  VC_W  target channel of write.
REQ-010 WDATA  in  WIDTH  write data.
REQ-011 RINC  in  1  read (pop) request.
REQ-012 RVC  in  VC_W  source channel of read.
REQ-013 RDATA  out  WIDTH  read data.
REQ-014 RVALID  out  1  RDATA holds valid popped/head data.
REQ-015 WFULL  out  NUM_VC  per-channel full.
REQ-016 REMPTY  out  NUM_VC  per-channel empty.
REQ-017 WAFULL  out  NUM_VC  per-channel almost-full.
REQ-018 OVF  out  1  sticky overflow error.
REQ-019 UDF  out  1  sticky underflow error.

Function
REQ-020 Each channel is an independent circular queue of DEPTH entries with PTR_W-bit write/read pointers (MSB = wrap bit); order preserved per channel only.
REQ-021 Empty[v] when pointers equal; full[v] when address bits equal and wrap bits differ; pointers wrap modulo 2*DEPTH.
REQ-022 Write accepted iff WINC=1, WVC<NUM_VC, WFULL[WVC]=0; data stored at write pointer, pointer increments at that edge.
REQ-023 Read accepted iff RINC=1, RVC<NUM_VC, REMPTY[RVC]=0; read pointer increments at that edge.
REQ-024 Acceptance uses flags from registered state before the edge; flags reflect an operation in the cycle after it.
REQ-025 Simultaneous write and read, different channels: both evaluated independently.
REQ-026 Simultaneous write and read, same full channel: read accepted, write rejected.
REQ-027 Simultaneous write and read, same empty channel: write accepted, read rejected; no bypass of WDATA to RDATA.
REQ-028 Simultaneous write and read, same partially-filled channel: both accepted, occupancy unchanged.
REQ-029 WAFULL[v] = (occupancy[v] >= AF_LEVEL), occupancy = wptr - rptr in PTR_W bits.
REQ-030 Rejected write (full or out-of-range WVC) with WINC=1 sets OVF; stored data and pointers unchanged.
REQ-031 Rejected read (empty or out-of-range RVC) with RINC=1 sets UDF; RVALID stays 0 for it.
REQ-032 OVF and UDF hold 1 until RST.

Reset
REQ-033 RST=1 at a rising edge: all pointers 0, REMPTY all 1, WFULL/WAFULL all 0, RVALID 0, RDATA 0, OVF 0, UDF 0.
REQ-034 RST dominates: WINC/RINC in a reset cycle are ignored and flag nothing; reset mid-operation discards all queued data.
REQ-035 Storage array is not reset.

Configuration
REQ-036 Macro SYNC_VC_FIFO_FWFT_EN selects first-word-fall-through read mode.
REQ-037 Defined: RDATA = head entry of channel RVC combinationally, RVALID = !REMPTY[RVC] (0 if RVC out of range), RINC pops the shown word.
REQ-038 Undefined: RDATA registered; accepted read at edge N puts the word on RDATA and RVALID=1 after edge N, for one cycle; otherwise RVALID=0 and RDATA holds last value.

Verification
REQ-039 Reset, write 0..15 to VC0 -> WAFULL[0]=1 after 14th write, WFULL[0]=1 after 16th, REMPTY[1..3]=1, OVF=0.
REQ-040 VC0 full, write 0xAA -> dropped, OVF=1; 16 reads return 0..15 in order, REMPTY[0]=1 after last.
REQ-041 Interleave writes VC1 0x10..0x13 and VC2 0x20..0x23 -> reads of VC2 then VC1 return 0x20..0x23 and 0x10..0x13, no cross-talk.
REQ-042 VC3 full, WINC+RINC on VC3 same cycle -> read accepted, write dropped, OVF=1, WFULL[3]=0 next cycle; empty VC2 WINC+RINC -> write accepted, UDF=1, REMPTY[2]=0 next cycle.
REQ-043 8 words in VC0, RST pulsed one cycle -> next cycle REMPTY all 1, OVF=UDF=0; write 0x5A, read returns 0x5A.
REQ-044 Run with and without SYNC_VC_FIFO_FWFT_EN -> FWFT: RDATA=head with RVALID=1 before RINC; registered: data one cycle after accepted RINC.
